// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite loader: RGB444 pixel layout,
// loader state encoding and the sprite pixel-count helper.
package sprite_pkg;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [NIB_W-1:0] r;
        logic [NIB_W-1:0] g;
        logic [NIB_W-1:0] b;
    } rgb444_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST,
        ST_SECOND,
        ST_CHK,
        ST_DONE
    } state_e;

    function automatic int unsigned spr_pixels(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

endpackage

// File: rtl/sprite_loader_byte_pair_packer.sv
// Holds the red nibble of the first byte and emits one registered
// RGB444 pixel plus a one-cycle write strobe per completed byte pair.
module byte_pair_packer
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             r_load_i,
    input  logic             px_load_i,
    input  logic [7:0]       byte_i,
    output logic             we_o,
    output logic [PIX_W-1:0] wdata_o
);

    logic [NIB_W-1:0] r_q;
    logic             we_q;
    rgb444_t          wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            we_q <= px_load_i;
            if (r_load_i) begin
                r_q <= byte_i[3:0];
            end
            if (px_load_i) begin
                wdata_q <= '{r: r_q, g: byte_i[7:4], b: byte_i[3:0]};
            end
        end
    end

    assign we_o    = we_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/sprite_loader.sv
// Byte-stream to sprite-BRAM writer (raster order). Define
// SPRITE_LOADER_CHKSUM_EN to add a trailing two's-complement checksum byte.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int unsigned SPR_W  = 90,
    parameter int unsigned SPR_H  = 26,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [PIX_W-1:0]  wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned       NPIX     = spr_pixels(SPR_W, SPR_H);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_q;
    logic              accept;
    logic              r_load;
    logic              px_load;

    assign in_ready = (state_q == ST_FIRST) || (state_q == ST_SECOND) || (state_q == ST_CHK);
    assign accept   = in_ready && in_valid;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_load  = 1'b0;
        px_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FIRST;
                    cnt_d   = '0;
                end
            end
            ST_FIRST: begin
                if (in_valid) begin
                    r_load  = 1'b1;
                    state_d = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (in_valid) begin
                    px_load = 1'b1;
                    if (cnt_q == LAST_PIX) begin
`ifdef SPRITE_LOADER_CHKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_FIRST;
                    end
                end
            end
            ST_CHK: begin
`ifdef SPRITE_LOADER_CHKSUM_EN
                if (in_valid) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= (state_q == ST_DONE);
            if (px_load) begin
                waddr_q <= cnt_q;
            end
        end
    end

`ifdef SPRITE_LOADER_CHKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d;
    logic [7:0] chk_total;

    // A correct check byte makes the 8-bit total of all accepted bytes zero.
    assign chk_total = in_data + sum_q;

    always_comb begin
        sum_d = sum_q;
        err_d = err_q;
        if (state_q == ST_IDLE && start) begin
            sum_d = '0;
            err_d = 1'b0;
        end else if (accept && state_q == ST_CHK) begin
            err_d = (chk_total != 8'd0);
        end else if (accept) begin
            sum_d = chk_total;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    byte_pair_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .r_load_i  (r_load),
        .px_load_i (px_load),
        .byte_i    (in_data),
        .we_o      (we),
        .wdata_o   (wdata)
    );

    assign waddr = waddr_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: random images streamed with and
// without gaps, ignored start, async reset mid-load, optional checksum.
module tb_sprite_loader;

    localparam int NPIX   = 90 * 26;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [11:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0]  img_b [0:2*NPIX-1];
    logic [11:0] mem   [0:NPIX-1];
    int exp_addr, wr_cnt, done_cnt, first_we_cyc, last_we_cyc;

    sprite_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference pixel: R from the low nibble of the first byte, G/B from the second.
    function automatic logic [11:0] exp_px(input int i);
        logic [7:0] b0, b1;
        b0 = img_b[2*i];
        b1 = img_b[2*i+1];
        return {b0[3:0], b1};
    endfunction

    always @(negedge clk) begin
        if (rst && we) begin
            check("waddr_seq", 32'(waddr), 32'(exp_addr));
            check("wdata", 32'(wdata), (int'(waddr) < NPIX) ? 32'(exp_px(int'(waddr))) : 32'hdead);
            if (int'(waddr) < NPIX) mem[waddr] = wdata;
            if (wr_cnt == 0) first_we_cyc = cyc;
            last_we_cyc = cyc;
            exp_addr++;
            wr_cnt++;
        end
        if (rst && done) done_cnt++;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},       32'(we),       32'd0);
        check({tag, "_waddr"},    32'(waddr),    32'd0);
        check({tag, "_wdata"},    32'(wdata),    32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Caller is always at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int w;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic new_image();
        for (int i = 0; i < 2*NPIX; i++) img_b[i] = 8'($urandom);
        for (int i = 0; i < NPIX; i++) mem[i] = 'x;
    endtask

    task automatic run_load(input int npix, input int gapmax, input int glitch_px,
                            input int abort_px, input bit bad_chk);
        logic [7:0] sum;
        int w, mism;
        logic exp_err;
        sum = 8'd0;
        exp_addr = 0;
        wr_cnt = 0;
        done_cnt = 0;
        pulse_start();
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < npix; i++) begin
            send_byte(img_b[2*i], $urandom_range(gapmax, 0));
            sum += img_b[2*i];
            if (i == glitch_px) begin
                pulse_start();
                check("glitch_busy", 32'(busy), 32'd1);
                check("glitch_ready", 32'(in_ready), 32'd1);
            end
            if (i == abort_px) begin
                repeat (2) @(negedge clk);
                #2 rst = 1'b0;
                #1 check_reset_outputs("async_rst");
                check("abort_writes", 32'(wr_cnt), 32'(abort_px));
                return;
            end
            send_byte(img_b[2*i+1], $urandom_range(gapmax, 0));
            sum += img_b[2*i+1];
        end
`ifdef SPRITE_LOADER_CHKSUM_EN
        send_byte((8'd0 - sum) ^ (bad_chk ? 8'h01 : 8'h00), $urandom_range(gapmax, 0));
        exp_err = bad_chk;
`else
        exp_err = 1'b0;
`endif
        w = 0;
        while (!done && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_with_done", 32'(busy), 32'd0);
        check("err", 32'(err), 32'(exp_err));
`ifndef SPRITE_LOADER_CHKSUM_EN
        check("done_after_last_we", 32'(cyc - last_we_cyc), 32'd1);
`endif
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("done_count", 32'(done_cnt), 32'd1);
        check("write_count", 32'(wr_cnt), 32'(NPIX));
        check("err_held", 32'(err), 32'(exp_err));
        if (gapmax == 0) check("b2b_rate", 32'(last_we_cyc - first_we_cyc), 32'(2*(NPIX-1)));
        mism = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] !== exp_px(i)) mism++;
        check("image_match", 32'(mism), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_addr = 0;
        wr_cnt = 0;
        done_cnt = 0;
        first_we_cyc = 0;
        last_we_cyc = 0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Bytes offered in IDLE without start are refused
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (8) @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_no_write", 32'(wr_cnt), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);

        // Full load, back-to-back bytes, with directed first pixels
        new_image();
        img_b[0] = 8'h0A;
        img_b[1] = 8'h5C;
        img_b[2] = 8'hF3;
        run_load(NPIX, 0, -1, -1, 1'b0);
        check("px0_a5c", 32'(mem[0]), 32'h0A5C);
        check("px1_r_low_nibble", 32'(mem[1][11:8]), 32'd3);

        // Same image with random stalls and an ignored start at pixel 100
        for (int i = 0; i < NPIX; i++) mem[i] = 'x;
        run_load(NPIX, 5, 100, -1, 1'b1);

        // Async reset between the bytes of pixel 500
        new_image();
        run_load(NPIX, 1, -1, 500, 1'b0);
        @(negedge clk);
        check("in_reset_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("after_release");

        // Fresh load after reset starts again from address 0
        new_image();
        run_load(NPIX, 0, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the sprite pixel memory that the draw controller reads.
- Accepts a byte stream over a valid/ready handshake from a UART or host bridge.
- Packs each pair of bytes into one 12-bit RGB444 pixel and writes it into a sprite BRAM through the BRAM's write port (we/addr/din), at addresses 0..SPR_W*SPR_H-1 in raster order.
- The draw controller scans the same raster order, so a loaded image displays unchanged.

Parameters:
- SPR_W, 90, sprite width in pixels.
- SPR_H, 26, sprite height in pixels.
- ADDR_W, 14, BRAM address width; SPR_W*SPR_H must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a byte this cycle.
- we  out  1  BRAM write enable, one-cycle pulse per pixel.
- waddr  out  ADDR_W  BRAM write address.
- wdata  out  12  pixel data {R[3:0],G[3:0],B[3:0]}.
- busy  out  1  high from the cycle after an accepted start until DONE is left.
- done  out  1  one-cycle pulse when the load completes.
- err  out  1  checksum mismatch flag (see Optional Feature); held until next start.

Behaviour:
- Reset (async assert, sync release): state=IDLE. in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0. Pixel counter=0, held R nibble=0.
- Handshake: a byte is accepted on a rising edge where in_valid and in_ready are both 1. in_ready is a registered/state-decoded output that does not depend combinationally on in_valid.
- Byte packing:
  - First byte of a pair: bits [3:0] = R; bits [7:4] are ignored.
  - Second byte: [7:4] = G, [3:0] = B.
- States:
  - IDLE: in_ready=0. start=1 -> FIRST; clear pixel counter, err, and the checksum accumulator.
  - FIRST: in_ready=1. On accept, latch R -> SECOND.
  - SECOND: in_ready=1. On accept:
    - Next cycle: we=1, waddr=pixel counter, wdata={R, byte[7:4], byte[3:0]}.
    - If counter == SPR_W*SPR_H-1 -> DONE (or CHK, with the feature); else counter+1 -> FIRST.
  - DONE: in_ready=0; done=1 for exactly one cycle; -> IDLE next cycle.
- Latency: we pulses exactly 1 cycle after the second-byte handshake. Back-to-back bytes sustain 1 pixel per 2 cycles.
- waddr and wdata hold their last values while we=0.
- Counter arithmetic is ADDR_W bits wide and compares against the constant SPR_W*SPR_H-1. It never wraps past the last pixel.
- start while busy: ignored; no restart, no state change.
- in_valid in IDLE/DONE: ignored, no byte consumed (in_ready=0).
- Stalls: in_valid low for any number of cycles in FIRST/SECOND holds state; the held R nibble is preserved.
- Reset mid-load: immediately returns to IDLE with all outputs at reset values. A partial image remains in BRAM; no completion pulse is produced.
- The block never reads the BRAM. Port B / the reader is untouched.

Optional Feature:
- Macro: SPRITE_LOADER_CHKSUM_EN.
- Enabled:
  - An 8-bit mod-256 sum of every accepted pixel byte is accumulated.
  - After the last pixel, the block goes to CHK (in_ready=1) and accepts one more byte.
  - If that byte equals the two's complement of the sum, err stays 0; otherwise err=1.
  - Then -> DONE. done pulses in both cases.
- Disabled: no CHK state; SECOND on the last pixel goes straight to DONE; err is tied to 0.

Decomposition:
- Shared package (sprite_pkg): RGB444 pixel width (12), nibble field positions, the state encoding enum (IDLE/FIRST/SECOND/CHK/DONE), and a SPR_PIXELS helper constant function.
- Sub-module: byte_pair_packer. Holds the R nibble and produces the registered wdata/we pulse from second-byte accept. The FSM and counter stay in sprite_loader.

Test Plan:
- Reset then start; stream 2*2340 bytes with in_valid held high -> 2340 we pulses at waddr 0..2339, one every 2 cycles. For byte pair 0x0A,0x5C: wdata=0xA5C. done pulses once, 1 cycle after the final we. busy falls with done.
- Random in_valid gaps (0-5 cycles) -> identical BRAM contents to the previous test; no duplicated or skipped address; R nibble is preserved across stalls.
- Pulse start during the load at pixel 100 -> ignored; counter continues 101, 102... with no reset to 0.
- Assert rst low midway between bytes of pixel 500 -> outputs go to 0 asynchronously, same cycle. After release, a new start loads from waddr 0.
- First byte 0xF3 -> R=3 (upper nibble ignored). With SPRITE_LOADER_CHKSUM_EN: a correct checksum byte gives err=0; a corrupted checksum byte gives err=1 with done still pulsing.
- in_valid high in IDLE with no start -> in_ready=0, we never asserts, byte not consumed.
